// File: rtl/clk_phase_align_pkg.sv
// Shared types and constants for the MMCM phase-alignment controller.
package clk_phase_align_pkg;

    typedef enum logic [2:0] {
        StRst,
        StWaitLock,
        StIdle,
        StStep,
        StWaitDone
    } state_e;

    localparam int unsigned RelockCntWidth = 8;

    function automatic logic [RelockCntWidth-1:0] sat_inc(input logic [RelockCntWidth-1:0] v);
        return (&v) ? v : v + RelockCntWidth'(1);
    endfunction

endpackage

// File: rtl/clk_phase_align_if.sv
// MMCM reset/lock and dynamic phase-shift port bundle.
interface clk_phase_align_if;

    logic rst;
    logic psen;
    logic psincdec;
    logic locked;
    logic psdone;

    modport master (
        output rst,
        output psen,
        output psincdec,
        input  locked,
        input  psdone
    );

    modport slave (
        input  rst,
        input  psen,
        input  psincdec,
        output locked,
        output psdone
    );

endinterface

// File: rtl/clk_phase_align_timeout_counter.sv
// Free-running up-counter with clear and a terminal-count flag at limit_i - 1.
module timeout_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic [Width-1:0] limit_i,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == limit_i - Width'(1));

    // Wrapping on terminal count lets the next timed state start from zero.
    always_comb begin
        cnt_d = cnt_q + Width'(1);
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_phase_align.sv
// Sequences MMCM reset/lock, then steps the dynamic phase shifter to a signed target,
// recovering automatically from lock loss or a stalled PSDONE handshake.
module clk_phase_align
    import clk_phase_align_pkg::*;
#(
    parameter int unsigned PHASE_BITS      = 10,
    parameter int unsigned MMCM_RST_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT    = 65535,
    parameter int unsigned PSDONE_TIMEOUT  = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic signed [PHASE_BITS-1:0] target_i,
    input  logic                         target_wr_i,
    clk_phase_align_if.master            mmcm,
    output logic signed [PHASE_BITS-1:0] phase_o,
    output logic                         locked_o,
    output logic                         busy_o,
    output logic [RelockCntWidth-1:0]    relock_cnt_o
);

    localparam int unsigned MaxA   = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned MaxCnt = (MaxA > PSDONE_TIMEOUT) ? MaxA : PSDONE_TIMEOUT;
    localparam int unsigned TimerW = $clog2(MaxCnt + 1);

    state_e                        state_q;
    logic signed [PHASE_BITS-1:0]  target_q, phase_q;
    logic signed [PHASE_BITS-1:0]  target_nxt, phase_stepped;
    logic                          mmcm_rst_q, psen_q, psincdec_q, locked_q, busy_q;
    logic [RelockCntWidth-1:0]     relock_q;
    logic [TimerW-1:0]             limit;
    logic                          timer_clr, timer_tc, recover;

    assign target_nxt    = target_wr_i ? target_i : target_q;
    assign phase_stepped = psincdec_q ? phase_q + PHASE_BITS'(1) : phase_q - PHASE_BITS'(1);

    always_comb begin
        case (state_q)
            StRst:      limit = TimerW'(MMCM_RST_CYCLES);
            StWaitLock: limit = TimerW'(LOCK_TIMEOUT);
            default:    limit = TimerW'(PSDONE_TIMEOUT);
        endcase
    end

    // Lock loss in WAIT_DONE leaves mid-count, so clear there explicitly.
    assign timer_clr = (state_q == StIdle) || (state_q == StStep) ||
                       ((state_q == StWaitDone) && !mmcm.locked);

    timeout_counter #(
        .Width (TimerW)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (timer_clr),
        .limit_i (limit),
        .tc_o    (timer_tc)
    );

    assign recover = ((state_q == StWaitLock) && !mmcm.locked && timer_tc) ||
                     ((state_q == StIdle) && !mmcm.locked) ||
                     ((state_q == StWaitDone) &&
                      (!mmcm.locked || (!mmcm.psdone && timer_tc)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            target_q <= '0;
        end else if (target_wr_i) begin
            target_q <= target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StRst;
            mmcm_rst_q <= 1'b1;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            phase_q    <= '0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b1;
            relock_q   <= '0;
        end else if (recover) begin
            state_q    <= StRst;
            mmcm_rst_q <= 1'b1;
            psen_q     <= 1'b0;
            phase_q    <= '0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b1;
            relock_q   <= sat_inc(relock_q);
        end else begin
            case (state_q)
                StRst: begin
                    if (timer_tc) begin
                        state_q    <= StWaitLock;
                        mmcm_rst_q <= 1'b0;
                    end
                end
                StWaitLock: begin
                    if (mmcm.locked) begin
                        state_q  <= StIdle;
                        locked_q <= 1'b1;
                        busy_q   <= (target_nxt != phase_q);
                    end
                end
                StIdle: begin
                    if (target_q != phase_q) begin
                        state_q    <= StStep;
                        psen_q     <= 1'b1;
                        psincdec_q <= (target_q > phase_q);
                        busy_q     <= 1'b1;
                    end else begin
                        busy_q <= (target_nxt != phase_q);
                    end
                end
                StStep: begin
                    state_q <= StWaitDone;
                    psen_q  <= 1'b0;
                end
                StWaitDone: begin
                    if (mmcm.psdone) begin
                        state_q <= StIdle;
                        phase_q <= phase_stepped;
                        busy_q  <= (target_nxt != phase_stepped);
                    end
                end
                default: state_q <= StRst;
            endcase
        end
    end

    assign mmcm.rst      = mmcm_rst_q;
    assign mmcm.psen     = psen_q;
    assign mmcm.psincdec = psincdec_q;
    assign phase_o       = phase_q;
    assign locked_o      = locked_q;
    assign busy_o        = busy_q;
    assign relock_cnt_o  = relock_q;

endmodule
